// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format follows the opcode alone, independent of state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE: imm_src = IMM_S;
            OP_BEQ:   imm_src = IMM_B;
            OP_JAL:   imm_src = IMM_J;
            default:  imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU operation decode from the FSM's ALUOp request and instruction fields.
module mc_aludec
    import riscv_mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct3)
                    // addi has op[5]=0, so an immediate with bit 30 set still adds
                    3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle control FSM: one datapath micro-step per clock, Moore outputs
// except the BEQ PC enable, which follows Zero in the same cycle.
module riscv_mc_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       IllegalOp
);

    state_t     state;
    state_t     next_state;
    logic       pcwrite_c;
    logic       memwrite_c;
    logic       irwrite_c;
    logic       regwrite_c;
    logic       instrdone_c;
    logic       illegalop_c;
    logic [1:0] aluop_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state and per-state control decode.
    always_comb begin
        next_state  = S_FETCH;
        pcwrite_c   = 1'b0;
        AdrSrc      = 1'b0;
        memwrite_c  = 1'b0;
        irwrite_c   = 1'b0;
        regwrite_c  = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        aluop_c     = ALUOP_ADD;
        instrdone_c = 1'b0;
        illegalop_c = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite_c  = 1'b1;
                pcwrite_c  = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_BEQ:            next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        illegalop_c = 1'b1;
                        instrdone_c = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                regwrite_c  = 1'b1;
                instrdone_c = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                memwrite_c  = 1'b1;
                instrdone_c = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RS1;
                aluop_c    = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                aluop_c    = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c  = 1'b1;
                instrdone_c = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = SRCA_RS1;
                aluop_c     = ALUOP_SUB;
                pcwrite_c   = Zero;
                instrdone_c = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcwrite_c  = 1'b1;
                next_state = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (aluop_c),
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

    // Reset pins the state to FETCH asynchronously; enables are also masked
    // so a write in flight drops in the same cycle reset rises.
    assign PCWrite   = pcwrite_c   & ~reset;
    assign MemWrite  = memwrite_c  & ~reset;
    assign IRWrite   = irwrite_c   & ~reset;
    assign RegWrite  = regwrite_c  & ~reset;
    assign InstrDone = instrdone_c & ~reset;
    assign IllegalOp = illegalop_c & ~reset;
    assign ImmSrc    = imm_src(op);

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller against an instruction-level model.
module tb_riscv_mc_controller;
    import riscv_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
    );

    wire [17:0] obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, IllegalOp};

    function automatic logic [1:0] m_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Mnemonic-level ALU op: sub only for R-type funct3=000 with bit 30 set.
    function automatic logic [2:0] m_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int m_latency(input logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b1100011: return 3;
            7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
            default:    return 2;
        endcase
    endfunction

    function automatic logic m_supported(input logic [6:0] o);
        return m_latency(o) != 2;
    endfunction

    function automatic logic [17:0] m_reset_vec(input logic [6:0] o);
        return {5'b00000, 2'b10, 2'b00, 2'b10, m_imm(o), 3'b000, 2'b00};
    endfunction

    // Expected control word for one named micro-step of an instruction.
    function automatic logic [17:0] m_ctrl(input state_t s, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7, input logic z);
        logic pcw, adr, mw, irw, rw, dn, il;
        logic [1:0] res, sa, sb;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; dn = 0; il = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        case (s)
            S_FETCH:    begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; il = !m_supported(o); dn = il; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  adr = 1;
            S_MEMWB:    begin res = 2'b01; rw = 1; dn = 1; end
            S_MEMWRITE: begin adr = 1; mw = 1; dn = 1; end
            S_EXECUTER: begin sa = 2'b10; alu = m_alu(o, f3, f7); end
            S_EXECUTEI: begin sa = 2'b10; sb = 2'b01; alu = m_alu(o, f3, f7); end
            S_ALUWB:    begin rw = 1; dn = 1; end
            S_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = z; dn = 1; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default:    ;
        endcase
        return {pcw, adr, mw, irw, rw, res, sa, sb, m_imm(o), alu, dn, il};
    endfunction

    // Runs one instruction starting in its FETCH cycle (called just after a rising edge).
    task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3,
                             input logic if7, input logic zb);
        state_t seq[$];
        logic [17:0] exp;
        int lat, dones, regw, memw, pcw;
        lat = 0; dones = 0; regw = 0; memw = 0; pcw = 0;
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (iop)
            7'b0000011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
            7'b0100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
            7'b0110011: begin seq.push_back(S_EXECUTER); seq.push_back(S_ALUWB); end
            7'b0010011: begin seq.push_back(S_EXECUTEI); seq.push_back(S_ALUWB); end
            7'b1100011: seq.push_back(S_BEQ);
            7'b1101111: begin seq.push_back(S_JAL); seq.push_back(S_ALUWB); end
            default: ;
        endcase
        op = iop; funct3 = if3; funct7b5 = if7;
        foreach (seq[i]) begin
            Zero = (seq[i] == S_BEQ) ? zb : 1'($urandom);
            @(negedge clk);
            checks++;
            if (dut.state !== seq[i]) begin
                errors++;
                $display("FAIL state op=%b step %0d: got %0d want %0d", iop, i, dut.state, seq[i]);
            end
            exp = m_ctrl(seq[i], iop, if3, if7, Zero);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ctrl op=%b f3=%0d f7=%b step %0d: got %h want %h",
                         iop, if3, if7, i, obs, exp);
            end
            if (InstrDone === 1'b1 && lat == 0) lat = i + 1;
            dones += int'(InstrDone === 1'b1);
            regw  += int'(RegWrite === 1'b1);
            memw  += int'(MemWrite === 1'b1);
            pcw   += int'(PCWrite === 1'b1);
            @(posedge clk);
            #1;
        end
        checks++;
        if (lat != m_latency(iop) || dones != 1) begin
            errors++;
            $display("FAIL latency op=%b: got %0d (done pulses %0d) want %0d (1)", iop, lat, dones, m_latency(iop));
        end
        checks++;
        if (regw != int'(iop inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b1101111}) ||
            memw != int'(iop == 7'b0100011)) begin
            errors++;
            $display("FAIL writes op=%b: got reg %0d mem %0d", iop, regw, memw);
        end
        checks++;
        if (pcw != 1 + int'(iop == 7'b1101111) + int'(iop == 7'b1100011 && zb)) begin
            errors++;
            $display("FAIL pcwrites op=%b zb=%b: got %0d", iop, zb, pcw);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 7'b0000000; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (dut.state !== S_FETCH || obs !== m_reset_vec(op)) begin
                errors++;
                $display("FAIL reset hold: got state %0d ctrl %h want 0 %h", dut.state, obs, m_reset_vec(op));
            end
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== m_ctrl(S_FETCH, op, 3'd0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset release: got %h want %h", obs, m_ctrl(S_FETCH, op, 3'd0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_load();   run_instr(7'b0000011, 3'd3, 1'b0, 1'b0); endtask
    task automatic test_store();  run_instr(7'b0100011, 3'd3, 1'b0, 1'b0); endtask

    task automatic test_alu_decode();
        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0);
        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);
        run_instr(7'b0110011, 3'd2, 1'b0, 1'b0);
        run_instr(7'b0010011, 3'd6, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'd7, 1'b0, 1'b0);
    endtask

    task automatic test_beq();
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);
        run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_jal();     run_instr(7'b1101111, 3'd5, 1'b1, 1'b0); endtask
    task automatic test_illegal(); run_instr(7'b1111111, 3'd0, 1'b0, 1'b0); endtask

    task automatic test_reset_mid_store();
        op = 7'b0100011; funct3 = 3'd3; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b1 || dut.state !== S_MEMWRITE) begin
            errors++;
            $display("FAIL memwrite before reset: got %b state %0d want 1 5", MemWrite, dut.state);
        end
        op = 7'b0000011;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== m_reset_vec(op) || dut.state !== S_FETCH) begin
            errors++;
            $display("FAIL async abort: got %h state %0d want %h 0", obs, dut.state, m_reset_vec(op));
        end
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== m_ctrl(S_FETCH, op, funct3, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL fetch after abort: got %h want %h", obs, m_ctrl(S_FETCH, op, funct3, 1'b0, 1'b0));
        end
        run_instr(7'b0000011, 3'd3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 6) == 6) begin
                do o = 7'($urandom); while (m_supported(o));
            end else begin
                o = ops[$urandom_range(0, 5)];
            end
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_alu_decode();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
